// File: rtl/core_pkg.sv
// Shared core definitions: load/store size encodings, LSU state type and the
// RV32I major opcodes also used by the main decoder.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // Access is rejected before touching the bus.
  function automatic logic lsu_access_err(input logic       is_rd,
                                          input logic       is_wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
    logic err;
    err = is_rd && is_wr;
    case (f3)
      F3_B:         ;
      F3_H:         if (off[0]) err = 1'b1;
      F3_W:         if (off != 2'b00) err = 1'b1;
      F3_BU:        if (is_wr) err = 1'b1;
      F3_HU:        if (is_wr || off[0]) err = 1'b1;
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables and replicated store
// data on the way out, load extraction and sign/zero extension on the way back.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be       = 4'b0000;
    st_lanes = 32'd0;
    ld_data  = 32'd0;
    shifted  = ld_word >> {byte_off, 3'b000};
    case (funct3)
      F3_B: begin
        be       = 4'b0001 << byte_off;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be       = 4'b0011 << byte_off;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        be       = 4'b1111;
        st_lanes = st_data;
        ld_data  = shifted;
      end
      F3_BU: begin
        be       = 4'b0001 << byte_off;
        ld_data  = {24'd0, shifted[7:0]};
      end
      F3_HU: begin
        be       = 4'b0011 << byte_off;
        ld_data  = {16'd0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time from the core onto a valid/ready
// data bus, with alignment checks, lane steering and an access timeout.
module load_store_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [10:0] TO_LIM = 11'(TIMEOUT);

  lsu_state_t  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        is_load_q, is_load_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        idle;
  logic        accept;
  logic        acc_err;
  logic [10:0] cnt_next;
  logic        timed_out;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_lanes;
  logic [31:0] al_ld;

  assign idle      = (state_q == ST_IDLE);
  assign accept    = idle && req_valid && (mem_read || mem_write);
  assign acc_err   = lsu_access_err(mem_read, mem_write, funct3, addr[1:0]);
  assign cnt_next  = {1'b0, cnt_q} + 11'd1;
  assign timed_out = (cnt_next >= TO_LIM);

  // Incoming request is steered while idle; latched access once the bus is busy.
  assign al_f3  = idle ? funct3    : f3_q;
  assign al_off = idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3   (al_f3),
    .byte_off (al_off),
    .st_data  (wdata),
    .ld_word  (bus_rdata),
    .be       (al_be),
    .st_lanes (al_lanes),
    .ld_data  (al_ld)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    off_d        = off_q;
    is_load_d    = is_load_q;
    bus_valid_d  = 1'b0;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          f3_d      = funct3;
          off_d     = addr[1:0];
          is_load_d = mem_read;
          if (acc_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = 10'd0;
            bus_valid_d = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = al_be;
            bus_wdata_d = mem_write ? al_lanes : 32'd0;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_next[9:0];
        // A handshake in the timeout cycle still counts as accepted by the bus.
        if (bus_ready) begin
          if (is_load_q) begin
            state_d = ST_WAIT;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          bus_valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_next[9:0];
        if (bus_rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = al_ld;
        end else if (timed_out) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 10'd0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      is_load_q    <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_be_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      is_load_q    <= is_load_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = idle;
  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
